rsa_encryptor: RTL

RSA_ENCRYPTOR -- requirements
Module: rsa_encryptor

---
 rtl/rsa_encryptor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/rsa_encryptor.sv
// rsa_encryptor: sequential modular exponentiation c = m^e mod n.
//
// Left-to-right square-and-multiply over WIDTH exponent bits (MSB first).
// Each modular multiply is interleaved shift-add, one multiplier bit per
// cycle. So every multiply takes exactly WIDTH cycles.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - begin one encryption (honoured only in IDLE)
//   msg    - plaintext m        exp - public exponent e    mod - modulus n
//   busy   - high during square/multiply cycles
//   done   - one-cycle completion pulse (FIN state)
//   err    - operands rejected (mod < 2 or msg >= mod), valid with done
//   cipher - result; holds after done until the next accepted start
//
// Build option: define RSA_ENC_CONST_TIME_EN to run the multiply phase for
// every exponent bit. The product is discarded for 0 bits. Latency is then
// 2*WIDTH*WIDTH cycles, independent of the exponent.
//
// Handshake: start is a request sampled only while busy=0 and done=0
// (IDLE). On that edge the operands are captured. The result is signalled
// by a single-cycle done, with err/cipher valid alongside it.
module rsa_encryptor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] mod,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] cipher
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQR  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] m_q,      m_d;
  logic [WIDTH-1:0] e_q,      e_d;
  logic [WIDTH-1:0] n_q,      n_d;
  logic [WIDTH-1:0] r_q,      r_d;       // exponentiation accumulator R
  logic [WIDTH-1:0] p_q,      p_d;       // partial product of current multiply
  logic [CW-1:0]    cnt_q,    cnt_d;     // multiplier bit index, counts down
  logic [CW-1:0]    bit_q,    bit_d;     // exponent bit index, counts down
  logic [WIDTH-1:0] cipher_q, cipher_d;
  logic             err_q,    err_d;

  // Datapath: one shift-add step of P = A*B mod n, with A = R.
  // The multiplier B is R while squaring and m while multiplying.
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   dbl, red1, sum, red2;
  logic [WIDTH-1:0] p_step;
  logic             last_cycle;
  logic             e_bit;
  logic             go_mul;
  logic [WIDTH-1:0] mul_res;

  always_comb begin
    b_sel = (state_q == MUL) ? m_q : r_q;
    // P < n, so 2P < 2n. A single conditional subtract restores P < n. The
    // extra bit holds the carry out of the doubling.
    dbl  = {p_q, 1'b0};
    red1 = (dbl >= {1'b0, n_q}) ? (dbl - {1'b0, n_q}) : dbl;
    sum  = red1 + {1'b0, r_q};
    red2 = (sum >= {1'b0, n_q}) ? (sum - {1'b0, n_q}) : sum;
    p_step     = b_sel[cnt_q] ? red2[WIDTH-1:0] : red1[WIDTH-1:0];
    last_cycle = (cnt_q == '0);
    e_bit      = e_q[bit_q];
`ifdef RSA_ENC_CONST_TIME_EN
    go_mul     = 1'b1;
`else
    go_mul     = e_bit;
`endif
    // For a 0 exponent bit, MUL only runs in the constant-time build, and
    // its product is dropped.
    mul_res    = e_bit ? p_step : r_q;
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    n_d      = n_q;
    r_d      = r_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    cipher_d = cipher_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d      = msg;
          e_d      = exp;
          n_d      = mod;
          r_d      = WIDTH'(1);
          p_d      = '0;
          cnt_d    = CW'(WIDTH - 1);
          bit_d    = CW'(WIDTH - 1);
          cipher_d = '0;
          if ((mod < WIDTH'(2)) || (msg >= mod)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            state_d = SQR;
          end
        end
      end

      SQR: begin
        if (last_cycle) begin
          r_d   = p_step;
          p_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          if (go_mul) begin
            state_d = MUL;
          end else if (bit_q == '0) begin
            cipher_d = p_step;
            state_d  = FIN;
          end else begin
            bit_d = bit_q - 1'b1;
          end
        end else begin
          p_d   = p_step;
          cnt_d = cnt_q - 1'b1;
        end
      end

      MUL: begin
        if (last_cycle) begin
          r_d   = mul_res;
          p_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          if (bit_q == '0) begin
            cipher_d = mul_res;
            state_d  = FIN;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = SQR;
          end
        end else begin
          p_d   = p_step;
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin  // FIN: always return to IDLE; start is ignored here
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      cipher_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      n_q      <= n_d;
      r_q      <= r_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      cipher_q <= cipher_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == SQR) || (state_q == MUL);
  assign done   = (state_q == FIN);
  assign err    = err_q;
  assign cipher = cipher_q;

endmodule
